// File: rtl/add_serial_param.sv
// Digit-serial WIDTH-bit adder/subtractor, LSB first, DIGIT bits per clock.
// Define ADD_SERIAL_SAT_EN to saturate out on signed overflow.
module add_serial_param #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_n;

    logic [WIDTH-1:0]       a_reg;
    logic [WIDTH-1:0]       b_reg;
    logic                   carry;
    logic [CW-1:0]          count;
    logic [DIGIT:0]         digit_sum;
    logic [DIGIT-1:0]       s;
    logic                   c;
    logic                   c_msb;
    logic                   ovf_raw;
    logic                   last;
    logic [WIDTH+DIGIT-1:0] out_cat;
    logic [WIDTH-1:0]       out_shift;
    logic [WIDTH-1:0]       out_last;

    assign digit_sum = {1'b0, a_reg[DIGIT-1:0]}
                     + {1'b0, b_reg[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry};
    assign s = digit_sum[DIGIT-1:0];
    assign c = digit_sum[DIGIT];

    // Ripple carry into the top bit of the digit, recovered from its sum bit.
    assign c_msb   = a_reg[DIGIT-1] ^ b_reg[DIGIT-1] ^ s[DIGIT-1];
    assign ovf_raw = c_msb ^ c;
    assign last    = (count == CW'(N - 1));

    assign out_cat   = {s, out};
    assign out_shift = out_cat[WIDTH+DIGIT-1:DIGIT];

`ifdef ADD_SERIAL_SAT_EN
    // On overflow the raw sign is wrong, so clamp toward the opposite sign.
    always_comb begin
        out_last = out_shift;
        if (ovf_raw) begin
            out_last = s[DIGIT-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                  : {1'b1, {(WIDTH-1){1'b0}}};
        end
    end
`else
    assign out_last = out_shift;
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (en) state_n = ADD;
            ADD:     if (last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n != IDLE);
            done  <= (state_n == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            count <= '0;
            out   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en) begin
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        carry <= sub;
                        count <= '0;
                        out   <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                    end
                end
                ADD: begin
                    a_reg <= a_reg >> DIGIT;
                    b_reg <= b_reg >> DIGIT;
                    carry <= c;
                    count <= count + CW'(1);
                    if (last) begin
                        out  <= out_last;
                        cout <= c;
                        ovf  <= ovf_raw;
                    end else begin
                        out <= out_shift;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
